exec_dispatcher: RTL and testbench
==================================

# exec_dispatcher

Dispatches batched transactions from the batch stage onto NUM_LANES parallel execution lanes. Holds one transaction at a time and tracks the read/write dependency vectors of every in-flight transaction per lane. A transaction issues only when it has no RAW/WAW/WAR hazard with in-flight work and a free lane exists. It sits downstream of the scheduler top-level's `m_axis_*` output and owns lane allocation and lock release.

## Interface
Reset: one clock; reset is synchronous and active-high.
- MAX_DEPENDENCIES, 256: dependency vector width
- NUM_LANES, 4: execution lanes, power of two, 2..16
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tvalid  in  1  input transaction valid
- s_axis_tready  out  1  input ready
- s_axis_tdata_owner_programID  in  64  transaction owner
- s_axis_tdata_read_dependencies  in  MAX_DEPENDENCIES  read set
- s_axis_tdata_write_dependencies  in  MAX_DEPENDENCIES  write set
- lane_valid  out  NUM_LANES  one-hot issue request
- lane_ready  in  NUM_LANES  per-lane accept
- lane_owner_programID  out  64  shared issue bus
- lane_read_dependencies  out  MAX_DEPENDENCIES  shared issue bus
- lane_write_dependencies  out  MAX_DEPENDENCIES  shared issue bus
- lane_done  in  NUM_LANES  per-lane completion pulse, releases that lane's locks
- lanes_busy  out  NUM_LANES  in-flight bitmap
- dispatched_count  out  32  transactions issued
- hazard_stall_cycles  out  32  cycles spent in STALL

## Operation
- States: IDLE, EVAL, ISSUE, STALL.
- IDLE:
  - s_axis_tready=1.
  - On handshake, capture the transaction into the hold register and go to EVAL.
- EVAL and STALL:
  - Form the lock union: union_r = OR of busy lanes' read sets; union_w = OR of busy lanes' write sets.
  - Hazard = |(hold_w & (union_r | union_w)) | |(hold_r & union_w).
  - If no hazard and at least one lane is free: select a lane round-robin from rr_ptr and go to ISSUE. Otherwise go to (or remain in) STALL.
- ISSUE:
  - lane_valid[sel]=1; the shared bus carries the hold register.
  - On lane_ready[sel]: set busy[sel], store the hold sets into lane sel's lock slot, set rr_ptr=(sel+1) mod NUM_LANES, increment dispatched_count, and go to IDLE.
  - lane_ready on any other lane is ignored.
- lane_done[i]:
  - If busy[i]: clear busy[i] and zero lane i's lock slot at the next edge.
  - If lane i is not busy, or i is the lane completing its ISSUE handshake in the same cycle: the pulse is ignored.
- An empty hold (all-zero read and write sets) never hazards.
- rst: all outputs 0, busy=0, lock slots=0, rr_ptr=0, counters=0, state=IDLE. A reset mid-ISSUE drops the held transaction.

## Timing
- Input handshake at cycle 0. EVAL at cycle 1. Earliest lane_valid at cycle 2.
- Back-to-back non-hazarding transactions: one issued per 3 cycles with lane_ready tied high.
- lane_valid and its bus stay stable until lane_ready. lane_valid never deasserts without a handshake.
- A lane_done in cycle n is visible to hazard evaluation in cycle n+1. A stalled transaction issues at the earliest at cycle n+2.
- s_axis_tready is 0 in EVAL, ISSUE and STALL.
- Counters wrap at 2^32. hazard_stall_cycles increments once per cycle in STALL.

## Configuration
- DISPATCH_STATS_EN:
  - Defined: dispatched_count and hazard_stall_cycles are live as described.
  - Undefined: no counter registers; both outputs tie to 32'd0; functional behaviour is identical.

## Structure
- Package svm_sched_pkg holds:
  - the state enum (IDLE/EVAL/ISSUE/STALL);
  - LANE_IDX_W = $clog2(NUM_LANES);
  - the hazard-check function shared with the conflict checker.
- Sub-module rr_lane_picker: combinational; inputs free mask and rr_ptr; outputs sel index and a found flag.

## Test plan
- Single txn, read={0}, write={1}, lanes idle, lane_ready=1 -> lane_valid=4'b0001 at cycle 2; lanes_busy=0001; dispatched_count=1.
- Txn A write={5} in flight on lane 0; txn B read={5} -> STALL. lane_done[0] at cycle 10 -> B issues on lane 1 at cycle 12.
- Four non-conflicting txns with lane_ready high -> lanes 0,1,2,3 in order. A fifth txn stalls until any lane_done, then takes that lane.
- lane_ready[sel] held low for 5 cycles -> lane_valid and bus stable throughout; s_axis_tready=0.
- lane_done on an idle lane, and lane_done[sel] coincident with the ISSUE handshake -> ignored; busy bit remains set.
- rst asserted during ISSUE -> next cycle lane_valid=0, lanes_busy=0, counters=0, s_axis_tready=1.

Source files
------------

// File: rtl/svm_sched_pkg.sv
// Shared types and helpers for the execution dispatcher: FSM state encoding,
// default lane-index width and the dependency hazard check.
package svm_sched_pkg;

   localparam int DEP_W         = 256;
   localparam int DEF_NUM_LANES = 4;
   localparam int LANE_IDX_W    = $clog2(DEF_NUM_LANES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      ISSUE = 2'd2,
      STALL = 2'd3
   } disp_state_t;

   // RAW/WAW/WAR check of a held transaction against the in-flight lock union.
   // An all-zero hold can never report a hazard.
   function automatic logic hazard_check(input logic [DEP_W-1:0] hold_r,
                                         input logic [DEP_W-1:0] hold_w,
                                         input logic [DEP_W-1:0] union_r,
                                         input logic [DEP_W-1:0] union_w);
      return (|(hold_w & (union_r | union_w))) | (|(hold_r & union_w));
   endfunction

endpackage

// File: rtl/exec_dispatcher_if.sv
// Bundle of the dispatcher's input stream, lane issue bus, completion and
// status signals. master = dispatcher side, slave = environment side.
interface exec_dispatcher_if #(
   parameter int MAX_DEPENDENCIES = 256,
   parameter int NUM_LANES        = 4
);
   logic                        s_axis_tvalid;
   logic                        s_axis_tready;
   logic [63:0]                 s_axis_tdata_owner_programID;
   logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies;
   logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies;
   logic [NUM_LANES-1:0]        lane_valid;
   logic [NUM_LANES-1:0]        lane_ready;
   logic [63:0]                 lane_owner_programID;
   logic [MAX_DEPENDENCIES-1:0] lane_read_dependencies;
   logic [MAX_DEPENDENCIES-1:0] lane_write_dependencies;
   logic [NUM_LANES-1:0]        lane_done;
   logic [NUM_LANES-1:0]        lanes_busy;
   logic [31:0]                 dispatched_count;
   logic [31:0]                 hazard_stall_cycles;

   modport master (
      input  s_axis_tvalid, s_axis_tdata_owner_programID,
             s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
             lane_ready, lane_done,
      output s_axis_tready, lane_valid, lane_owner_programID,
             lane_read_dependencies, lane_write_dependencies,
             lanes_busy, dispatched_count, hazard_stall_cycles
   );

   modport slave (
      output s_axis_tvalid, s_axis_tdata_owner_programID,
             s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
             lane_ready, lane_done,
      input  s_axis_tready, lane_valid, lane_owner_programID,
             lane_read_dependencies, lane_write_dependencies,
             lanes_busy, dispatched_count, hazard_stall_cycles
   );
endinterface

// File: rtl/rr_lane_picker.sv
// Combinational round-robin lane picker: first free lane at or after rr_ptr.
module rr_lane_picker
   import svm_sched_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int IDX_W     = LANE_IDX_W
) (
   input  logic [NUM_LANES-1:0] free,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [IDX_W-1:0]     sel,
   output logic                 found
);

   logic [IDX_W-1:0] idx;

   // Scan downward so the smallest offset from rr_ptr wins; index wraps
   // naturally because NUM_LANES is a power of two.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         idx = rr_ptr + IDX_W'(i);
         if (free[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

endmodule

// File: rtl/exec_dispatcher.sv
// Execution dispatcher: holds one transaction, checks it against the lock
// sets of in-flight lanes, and issues it round-robin to a free lane.
// Optional statistics counters are enabled with `define DISPATCH_STATS_EN.
module exec_dispatcher
   import svm_sched_pkg::*;
#(
   parameter int MAX_DEPENDENCIES = DEP_W,
   parameter int NUM_LANES        = DEF_NUM_LANES
) (
   input logic                clk,
   input logic                rst,
   exec_dispatcher_if.master  bus
);

   localparam int SEL_W = $clog2(NUM_LANES);

   disp_state_t                 state, state_nxt;
   logic [63:0]                 hold_owner;
   logic [MAX_DEPENDENCIES-1:0] hold_r, hold_w;
   logic [NUM_LANES-1:0]        busy;
   logic [MAX_DEPENDENCIES-1:0] lock_r [NUM_LANES];
   logic [MAX_DEPENDENCIES-1:0] lock_w [NUM_LANES];
   logic [MAX_DEPENDENCIES-1:0] union_r, union_w;
   logic [SEL_W-1:0]            rr_ptr, sel_q, pick_sel;
   logic [NUM_LANES-1:0]        free_mask;
   logic                        pick_found;
   logic                        hazard;
   logic                        in_hs, issue_hs, eval_go;

   assign in_hs     = (state == IDLE) && bus.s_axis_tvalid;
   assign issue_hs  = (state == ISSUE) && bus.lane_ready[sel_q];
   assign free_mask = ~busy;
   assign hazard    = hazard_check(hold_r, hold_w, union_r, union_w);
   assign eval_go   = ((state == EVAL) || (state == STALL)) && !hazard && pick_found;
   assign bus.lanes_busy = busy;

   rr_lane_picker #(
      .NUM_LANES (NUM_LANES),
      .IDX_W     (SEL_W)
   ) u_picker (
      .free   (free_mask),
      .rr_ptr (rr_ptr),
      .sel    (pick_sel),
      .found  (pick_found)
   );

   // Lock union over every busy lane's read and write sets.
   always_comb begin
      union_r = '0;
      union_w = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (busy[i]) begin
            union_r = union_r | lock_r[i];
            union_w = union_w | lock_w[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (bus.s_axis_tvalid) state_nxt = EVAL;
         EVAL, STALL: state_nxt = eval_go ? ISSUE : STALL;
         ISSUE:       if (bus.lane_ready[sel_q]) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Outputs: the issue bus is driven only while a lane request is open.
   always_comb begin
      bus.s_axis_tready           = (state == IDLE);
      bus.lane_valid              = '0;
      bus.lane_owner_programID    = '0;
      bus.lane_read_dependencies  = '0;
      bus.lane_write_dependencies = '0;
      if (state == ISSUE) begin
         bus.lane_valid[sel_q]       = 1'b1;
         bus.lane_owner_programID    = hold_owner;
         bus.lane_read_dependencies  = hold_r;
         bus.lane_write_dependencies = hold_w;
      end
   end

   // Hold register: data path, loaded on the input handshake only.
   always_ff @(posedge clk) begin
      if (in_hs) begin
         hold_owner <= bus.s_axis_tdata_owner_programID;
         hold_r     <= bus.s_axis_tdata_read_dependencies;
         hold_w     <= bus.s_axis_tdata_write_dependencies;
      end
   end

   // Lane selection latch and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q  <= '0;
         rr_ptr <= '0;
      end else begin
         if (eval_go)  sel_q  <= pick_sel;
         if (issue_hs) rr_ptr <= sel_q + SEL_W'(1);
      end
   end

   // Busy bitmap and per-lane lock slots; an issue into a lane overrides a
   // completion pulse on that same lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            lock_r[i] <= '0;
            lock_w[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (issue_hs && (sel_q == SEL_W'(i))) begin
               busy[i]   <= 1'b1;
               lock_r[i] <= hold_r;
               lock_w[i] <= hold_w;
            end else if (bus.lane_done[i] && busy[i]) begin
               busy[i]   <= 1'b0;
               lock_r[i] <= '0;
               lock_w[i] <= '0;
            end
         end
      end
   end

`ifdef DISPATCH_STATS_EN
   logic [31:0] disp_cnt, stall_cnt;

   // Issue and stall counters, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (issue_hs)         disp_cnt  <= disp_cnt + 32'd1;
         if (state == STALL)   stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign bus.dispatched_count    = disp_cnt;
   assign bus.hazard_stall_cycles = stall_cnt;
`else
   assign bus.dispatched_count    = 32'd0;
   assign bus.hazard_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_exec_dispatcher.sv
// Directed bench for exec_dispatcher: table-driven lane allocation plus
// hand-written hazard, back-pressure, done-pulse and reset sequences.
module tb_exec_dispatcher;
   import svm_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   exec_dispatcher_if #(.MAX_DEPENDENCIES(256), .NUM_LANES(4)) dif ();

   exec_dispatcher #(.MAX_DEPENDENCIES(256), .NUM_LANES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   typedef struct {
      int          rd_bit;
      int          wr_bit;
      logic [63:0] owner;
      int          done_lane;
      logic [3:0]  exp_valid;
      logic [3:0]  exp_busy;
   } vec_t;

   vec_t tbl [5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] bitv(input int b);
      logic [255:0] v;
      v = '0;
      if (b >= 0) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] cnt_exp(input int v);
`ifdef DISPATCH_STATS_EN
      return 32'(v);
`else
      return (v > 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Present one transaction and return one cycle after its handshake.
   task automatic send(input logic [63:0] owner, input logic [255:0] rd, input logic [255:0] wr);
      int guard;
      guard = 0;
      dif.s_axis_tvalid                   = 1'b1;
      dif.s_axis_tdata_owner_programID    = owner;
      dif.s_axis_tdata_read_dependencies  = rd;
      dif.s_axis_tdata_write_dependencies = wr;
      while (dif.s_axis_tready !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      if (guard >= 20) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: tready stayed %b, required 1", dif.s_axis_tready);
      end
      step();
      dif.s_axis_tvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]  own;
      logic [255:0] rd, wr;

      tbl[0] = '{10, 20, 64'hA0, -1, 4'b0001, 4'b0001};
      tbl[1] = '{11, 21, 64'hA1, -1, 4'b0010, 4'b0011};
      tbl[2] = '{12, 22, 64'hA2, -1, 4'b0100, 4'b0111};
      tbl[3] = '{13, 23, 64'hA3, -1, 4'b1000, 4'b1111};
      tbl[4] = '{30, 31, 64'hA4,  2, 4'b0100, 4'b1111};

      dif.s_axis_tvalid                   = 1'b0;
      dif.s_axis_tdata_owner_programID    = '0;
      dif.s_axis_tdata_read_dependencies  = '0;
      dif.s_axis_tdata_write_dependencies = '0;
      dif.lane_ready                      = 4'b1111;
      dif.lane_done                       = 4'b0000;

      // Reset state and a single transaction.
      do_reset();
      check("rst_lane_valid", dif.lane_valid, 4'b0000);
      check("rst_busy", dif.lanes_busy, 4'b0000);
      check("rst_tready", dif.s_axis_tready, 1'b1);
      check("rst_owner_bus", dif.lane_owner_programID, 64'd0);
      check("rst_disp", dif.dispatched_count, 32'd0);
      check("rst_stall", dif.hazard_stall_cycles, 32'd0);
      send(64'h11, bitv(0), bitv(1));
      check("t1_eval_valid", dif.lane_valid, 4'b0000);
      check("t1_eval_tready", dif.s_axis_tready, 1'b0);
      step();
      check("t1_valid", dif.lane_valid, 4'b0001);
      check("t1_owner", dif.lane_owner_programID, 64'h11);
      check("t1_rd", dif.lane_read_dependencies, bitv(0));
      check("t1_wr", dif.lane_write_dependencies, bitv(1));
      step();
      check("t1_busy", dif.lanes_busy, 4'b0001);
      check("t1_disp", dif.dispatched_count, cnt_exp(1));
      check("t1_tready", dif.s_axis_tready, 1'b1);

      // RAW hazard: B stalls behind A until lane 0 completes.
      do_reset();
      send(64'h1, bitv(-1), bitv(5));
      step();
      check("t2_a_valid", dif.lane_valid, 4'b0001);
      step();
      check("t2_a_busy", dif.lanes_busy, 4'b0001);
      send(64'h2, bitv(5), bitv(-1));
      for (int c = 4; c < 10; c++) begin
         check("t2_stall_valid", dif.lane_valid, 4'b0000);
         check("t2_stall_tready", dif.s_axis_tready, 1'b0);
         step();
      end
      dif.lane_done = 4'b0001;
      check("t2_c10_valid", dif.lane_valid, 4'b0000);
      step();
      dif.lane_done = 4'b0000;
      check("t2_c11_valid", dif.lane_valid, 4'b0000);
      check("t2_c11_busy", dif.lanes_busy, 4'b0000);
      step();
      check("t2_c12_valid", dif.lane_valid, 4'b0010);
      check("t2_c12_owner", dif.lane_owner_programID, 64'h2);
      check("t2_c12_rd", dif.lane_read_dependencies, bitv(5));
      check("t2_stall_cnt", dif.hazard_stall_cycles, cnt_exp(7));
      step();
      check("t2_busy", dif.lanes_busy, 4'b0010);
      check("t2_disp", dif.dispatched_count, cnt_exp(2));

      // Table: fill all four lanes in order, then a fifth waits for a free lane.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(tbl[i].owner, bitv(tbl[i].rd_bit), bitv(tbl[i].wr_bit));
         check("tb_eval_valid", dif.lane_valid, 4'b0000);
         step();
         if (tbl[i].done_lane >= 0) begin
            for (int k = 0; k < 4; k++) begin
               check("tb_full_valid", dif.lane_valid, 4'b0000);
               check("tb_full_tready", dif.s_axis_tready, 1'b0);
               if (k < 3) step();
            end
            dif.lane_done = 4'(bitv(tbl[i].done_lane));
            step();
            dif.lane_done = 4'b0000;
            check("tb_done_valid", dif.lane_valid, 4'b0000);
            check("tb_done_busy", dif.lanes_busy, tbl[i].exp_busy & ~4'(bitv(tbl[i].done_lane)));
            step();
         end
         check("tb_valid", dif.lane_valid, tbl[i].exp_valid);
         check("tb_owner", dif.lane_owner_programID, tbl[i].owner);
         check("tb_rd", dif.lane_read_dependencies, bitv(tbl[i].rd_bit));
         check("tb_wr", dif.lane_write_dependencies, bitv(tbl[i].wr_bit));
         step();
         check("tb_busy", dif.lanes_busy, tbl[i].exp_busy);
         check("tb_after_valid", dif.lane_valid, 4'b0000);
      end
      check("tb_disp", dif.dispatched_count, cnt_exp(5));
      check("tb_stall_cnt", dif.hazard_stall_cycles, cnt_exp(5));

      // Back-pressure: lane_ready low on the selected lane, high elsewhere.
      do_reset();
      own = 64'hDEAD_BEEF_0000_0042;
      rd  = bitv(7) | bitv(100);
      wr  = bitv(255);
      dif.lane_ready = 4'b0000;
      send(own, rd, wr);
      step();
      dif.lane_ready = 4'b1110;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", dif.lane_valid, 4'b0001);
         check("bp_owner", dif.lane_owner_programID, own);
         check("bp_rd", dif.lane_read_dependencies, rd);
         check("bp_wr", dif.lane_write_dependencies, wr);
         check("bp_tready", dif.s_axis_tready, 1'b0);
         check("bp_busy", dif.lanes_busy, 4'b0000);
         step();
      end
      check("bp_hold_valid", dif.lane_valid, 4'b0001);
      dif.lane_ready = 4'b0001;
      step();
      check("bp_busy_after", dif.lanes_busy, 4'b0001);
      check("bp_valid_after", dif.lane_valid, 4'b0000);

      // Done on an idle lane, and done coincident with the issue handshake.
      dif.lane_ready = 4'b1111;
      dif.lane_done  = 4'b1000;
      step();
      dif.lane_done  = 4'b0000;
      check("dn_idle_busy", dif.lanes_busy, 4'b0001);
      send(64'h55, bitv(40), bitv(41));
      step();
      check("dn_valid", dif.lane_valid, 4'b0010);
      dif.lane_done = 4'b0010;
      step();
      dif.lane_done = 4'b0000;
      check("dn_coincident_busy", dif.lanes_busy, 4'b0011);
      step();
      check("dn_busy_hold", dif.lanes_busy, 4'b0011);

      // Reset while a request is open on the issue bus.
      dif.lane_ready = 4'b0000;
      send(64'h66, bitv(50), bitv(51));
      step();
      check("rs_valid_pre", dif.lane_valid, 4'b0100);
      check("rs_disp_pre", dif.dispatched_count, cnt_exp(2));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rs_valid", dif.lane_valid, 4'b0000);
      check("rs_busy", dif.lanes_busy, 4'b0000);
      check("rs_tready", dif.s_axis_tready, 1'b1);
      check("rs_disp", dif.dispatched_count, 32'd0);
      check("rs_stall", dif.hazard_stall_cycles, 32'd0);
      check("rs_owner_bus", dif.lane_owner_programID, 64'd0);
      dif.lane_ready = 4'b1111;
      send(64'h77, bitv(60), bitv(61));
      step();
      check("rs_new_valid", dif.lane_valid, 4'b0001);
      check("rs_new_owner", dif.lane_owner_programID, 64'h77);
      step();
      check("rs_new_busy", dif.lanes_busy, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
